// File: rtl/qld_pkg.sv
// qld_pkg: shared widths, log-domain types and saturation constants for qld_pipe.
package qld_pkg;

    localparam int OP_W   = 16;
    localparam int K_W    = 4;
    localparam int FRAC_W = 5;
    localparam int LOG_W  = 9;
    localparam int D_W    = 10;
    localparam int Q_W    = 32;

    typedef logic [LOG_W-1:0] log_t;

    localparam logic [Q_W-1:0] Q_POS_SAT = 32'h7FFF_FFFF;
    localparam logic [Q_W-1:0] Q_NEG_SAT = 32'h8000_0000;

    // One's-complement magnitude; bit OP_W-1 of the result is always zero.
    function automatic logic [OP_W-1:0] ones_abs(input logic [OP_W-1:0] v);
        return v ^ {OP_W{v[OP_W-1]}};
    endfunction

endpackage

// File: rtl/qld_if.sv
// qld_if: operand/result valid-ready bundle between qld_pipe and its neighbours.
interface qld_if;
    import qld_pkg::*;

    logic [OP_W-1:0] x_i;
    logic [OP_W-1:0] y_i;
    logic            valid_i;
    logic            ready_o;
    logic [Q_W-1:0]  q_o;
    logic            dz_o;
    logic            valid_o;
    logic            ready_i;

    modport slave  (input  x_i, y_i, valid_i, ready_i,
                    output ready_o, q_o, dz_o, valid_o);
    modport master (output x_i, y_i, valid_i, ready_i,
                    input  ready_o, q_o, dz_o, valid_o);
endinterface

// File: rtl/qld_log_enc.sv
// qld_log_enc: combinational magnitude -> {k, f} log encoder plus zero flag.
// With QLD_ROUND_EN defined the fraction is rounded (saturating) instead of truncated.
module qld_log_enc
    import qld_pkg::*;
(
    input  logic [OP_W-1:0]   abs_i,
    output logic [K_W-1:0]    k_o,
    output logic [FRAC_W-1:0] f_o,
    output logic              zero_o
);

    logic [K_W-1:0] k_s;

    // leading-one index; the last set bit seen wins
    always_comb begin
        k_s = 4'd0;
        for (int i = 0; i < OP_W; i++) begin
            k_s = abs_i[i] ? i[K_W-1:0] : k_s;
        end
    end

`ifdef QLD_ROUND_EN
    // Low bit of the window is the first bit below the kept fraction.
    logic [FRAC_W:0] win_s;
    logic [FRAC_W:0] f_sum_s;

    assign win_s   = (FRAC_W+1)'({abs_i, 6'd0} >> k_s);
    assign f_sum_s = {1'b0, win_s[FRAC_W:1]} + {5'd0, win_s[0]};
    assign f_o     = f_sum_s[FRAC_W] ? 5'd31 : f_sum_s[FRAC_W-1:0];
`else
    logic [FRAC_W-1:0] win_s;

    assign win_s = FRAC_W'({abs_i, 5'd0} >> k_s);
    assign f_o   = win_s;
`endif

    assign k_o    = k_s;
    assign zero_o = (abs_i == 16'd0);

endmodule

// File: rtl/qld_pipe.sv
// qld_pipe: 3-stage elastic log-domain approximate divider, result in Q23.8.
// Optional macro QLD_ROUND_EN selects rounded log fractions (see qld_log_enc).
module qld_pipe
    import qld_pkg::*;
(
    input  logic clk_i,
    input  logic rstn_i,
    qld_if.slave bus
);

    logic en1_s, en2_s, en3_s;
    logic ld1_s, ld2_s, ld3_s;

    logic [OP_W-1:0]   x_abs_s, y_abs_s;
    logic [K_W-1:0]    x_k_s, y_k_s;
    logic [FRAC_W-1:0] x_f_s, y_f_s;
    logic              x_zero_s, y_zero_s;

    logic v1_q, v2_q, v3_q;

    log_t s1_x_log_d, s1_y_log_d, s1_x_log_q, s1_y_log_q;
    logic s1_sign_d, s1_sign_q, s1_x_zero_q, s1_y_zero_q;

    logic [D_W-1:0] s2_diff_d, s2_diff_q;
    logic           s2_sign_q, s2_x_zero_q, s2_y_zero_q;

    logic [Q_W-1:0] s3_q_d, s3_q_q;
    logic           s3_dz_d, s3_dz_q;

    logic [4:0]      c_s;
    logic [5:0]      sh_s, sh_neg_s;
    logic [FRAC_W:0] m_s;
    logic [Q_W-1:0]  m_ext_s, mag_s;

    // A stage loads when empty or when its contents move on this cycle.
    assign en3_s = ~v3_q | bus.ready_i;
    assign en2_s = ~v2_q | en3_s;
    assign en1_s = ~v1_q | en2_s;
    assign ld1_s = en1_s & bus.valid_i;
    assign ld2_s = en2_s & v1_q;
    assign ld3_s = en3_s & v2_q;

    assign x_abs_s = ones_abs(bus.x_i);
    assign y_abs_s = ones_abs(bus.y_i);

    qld_log_enc u_enc_x (.abs_i(x_abs_s), .k_o(x_k_s), .f_o(x_f_s), .zero_o(x_zero_s));
    qld_log_enc u_enc_y (.abs_i(y_abs_s), .k_o(y_k_s), .f_o(y_f_s), .zero_o(y_zero_s));

    assign s1_x_log_d = {x_k_s, x_f_s};
    assign s1_y_log_d = {y_k_s, y_f_s};
    assign s1_sign_d  = bus.x_i[OP_W-1] ^ bus.y_i[OP_W-1];

    assign s2_diff_d = {1'b0, s1_x_log_q} - {1'b0, s1_y_log_q};

    // Integer part of the log difference, biased by the 3 fraction bits dropped from Q.8.
    assign c_s      = s2_diff_q[D_W-1:FRAC_W];
    assign m_s      = {1'b1, s2_diff_q[FRAC_W-1:0]};
    assign sh_s     = {c_s[4], c_s} + 6'd3;
    assign sh_neg_s = 6'd0 - sh_s;
    assign m_ext_s  = {{(Q_W-FRAC_W-1){1'b0}}, m_s};

    // antilog shift, sign application and zero-operand overrides
    always_comb begin
        mag_s   = {Q_W{1'b0}};
        s3_q_d  = {Q_W{1'b0}};
        s3_dz_d = 1'b0;
        if (sh_s[5]) begin
            mag_s = m_ext_s >> sh_neg_s;
        end else begin
            mag_s = m_ext_s << sh_s;
        end
        if (s2_y_zero_q) begin
            s3_dz_d = 1'b1;
            s3_q_d  = s2_sign_q ? Q_NEG_SAT : Q_POS_SAT;
        end else if (s2_x_zero_q) begin
            s3_q_d  = 32'd0;
        end else begin
            s3_q_d  = mag_s ^ {Q_W{s2_sign_q}};
        end
    end

    // stage valid bits
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
        end else begin
            if (en1_s) v1_q <= bus.valid_i;
            if (en2_s) v2_q <= v1_q;
            if (en3_s) v3_q <= v2_q;
        end
    end

    // stage 1: log-encoded operands, zero flags, result sign
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            s1_x_log_q  <= 9'd0;
            s1_y_log_q  <= 9'd0;
            s1_x_zero_q <= 1'b0;
            s1_y_zero_q <= 1'b0;
            s1_sign_q   <= 1'b0;
        end else if (ld1_s) begin
            s1_x_log_q  <= s1_x_log_d;
            s1_y_log_q  <= s1_y_log_d;
            s1_x_zero_q <= x_zero_s;
            s1_y_zero_q <= y_zero_s;
            s1_sign_q   <= s1_sign_d;
        end
    end

    // stage 2: log difference
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            s2_diff_q   <= 10'd0;
            s2_x_zero_q <= 1'b0;
            s2_y_zero_q <= 1'b0;
            s2_sign_q   <= 1'b0;
        end else if (ld2_s) begin
            s2_diff_q   <= s2_diff_d;
            s2_x_zero_q <= s1_x_zero_q;
            s2_y_zero_q <= s1_y_zero_q;
            s2_sign_q   <= s1_sign_q;
        end
    end

    // stage 3: final quotient and divide-by-zero flag
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            s3_q_q  <= 32'd0;
            s3_dz_q <= 1'b0;
        end else if (ld3_s) begin
            s3_q_q  <= s3_q_d;
            s3_dz_q <= s3_dz_d;
        end
    end

    assign bus.ready_o = en1_s;
    assign bus.valid_o = v3_q;
    assign bus.q_o     = s3_q_q;
    assign bus.dz_o    = s3_dz_q;

endmodule

// File: doc/qld_pipe.md
QLD_PIPE -- requirements
Module: qld_pipe

Interface
REQ-001 Parameters: none; all widths are fixed by package qld_pkg.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset, with these ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rstn_i  in  1  asynchronous active-low reset.
- x_i  in  16  signed dividend.
- y_i  in  16  signed divisor.
- valid_i  in  1  input operands valid.
- ready_o  out  1  block can accept an operand pair.
- q_o  out  32  signed approximate quotient, Q23.8.
- dz_o  out  1  divide-by-zero flag, aligned with q_o.
- valid_o  out  1  q_o/dz_o valid.
- ready_i  in  1  downstream accepts result.

Function
REQ-003 Input transfer SHALL occur when valid_i & ready_o are both high. Output transfer SHALL occur when valid_o & ready_i are both high.
REQ-004 Magnitude SHALL be the one's complement: abs = operand XOR {16{operand[15]}}. Sign SHALL be x_i[15] XOR y_i[15].
REQ-005 Log encoding, per operand:
- k = 4-bit index of the leading one of abs.
- f = 5 bits immediately below the leading one, zero-padded when fewer than 5 such bits exist.
- log = {k,f} (9 bits unsigned).
- zero flag = (abs == 0).
REQ-006 Log difference: d = x_log - y_log, computed as a 10-bit two's-complement value. c = d[9:5] (signed, -16..15). m = {1'b1, d[4:0]}.
REQ-007 Magnitude result: s = c + 3. If s >= 0, mag = m << s; otherwise mag = m >> -s. The result SHALL be 32 bits wide and never overflow (max bit 23).
REQ-008 q_o SHALL be mag XOR {32{sign}}.
REQ-009 If y is zero: dz_o = 1 and q_o = 32'h7FFFFFFF, or 32'h80000000 when sign = 1. This SHALL apply even if x is also zero.
REQ-010 If x is zero and y is non-zero: q_o = 0 and dz_o = 0.
REQ-011 Pipeline SHALL be 3 register stages:
- S1: abs, log encode, zero flags, sign.
- S2: subtraction.
- S3: antilog, sign, special cases.
Latency from input transfer to valid_o SHALL be exactly 3 cycles when ready_i is held high.
REQ-012 Elastic pipeline:
- Each stage SHALL hold a valid bit.
- A stage SHALL load when it is empty or its contents advance in the same cycle.
- ready_o = ~S1.valid | S1 advances.
REQ-013 Throughput SHALL be 1 result/cycle with no bubbles while ready_i = 1.
REQ-014 With ready_i = 0, the pipeline SHALL fill to 3 entries, then drop ready_o. Results SHALL be delivered in order, with none lost or duplicated.
REQ-015 On simultaneous output transfer and input transfer into a full pipeline, all stages SHALL shift and the new pair SHALL be accepted in the same cycle.
REQ-016 q_o and dz_o SHALL remain stable while valid_o = 1 and ready_i = 0.

Reset
REQ-017 rstn_i low SHALL asynchronously clear all stage valid bits and data registers. Reset values: q_o = 0, dz_o = 0, valid_o = 0, ready_o = 1 (combinational from the empty S1).
REQ-018 Reset asserted mid-operation SHALL discard all in-flight operations. The first input after release SHALL produce its result 3 cycles later.

Configuration
REQ-019 Macro QLD_ROUND_EN:
- When defined, f SHALL be rounded: add the bit below the 5-bit field, saturating at 31; k is unchanged.
- When undefined, f SHALL be truncated.
- Latency and interface SHALL be identical in both cases.

Structure
REQ-020 Package qld_pkg SHALL hold LOG_W = 9, FRAC_W = 5, Q_W = 32, typedef log_t (9-bit), and constants Q_POS_SAT/Q_NEG_SAT.
REQ-021 Sub-module qld_log_enc (abs -> k, f, zero, purely combinational) SHALL be instantiated twice in S1.

Verification
REQ-022 x = 256, y = 16 -> q_o = 32'h00001000 (16.0), dz_o = 0, valid_o exactly 3 cycles after the transfer.
REQ-023 x = 3, y = 2 -> q_o = 32'h00000180 (1.5).
REQ-024 x = 16'hFF00, y = 16 -> q_o = 32'hFFFFF03F (one's complement of 4032). Result is the same with QLD_ROUND_EN, because of saturation.
REQ-025 Zero-operand cases:
- y = 0, x = 5 -> dz_o = 1, q_o = 32'h7FFFFFFF.
- y = 0, x = -5 -> q_o = 32'h80000000.
- x = 0, y = 7 -> q_o = 0, dz_o = 0.
REQ-026 Backpressure: ready_i = 0 for 6 cycles while 5 pairs are offered -> ready_o falls after 3 accepts. After ready_i rises, 5 results emerge in order, back-to-back.
REQ-027 Reset after 2 accepts, before any output -> valid_o stays 0. A new pair after release yields exactly one result 3 cycles later.
